// File: rtl/snake_pkg.sv
// Shared definitions for the snake renderer: grid geometry defaults, cell encodings,
// FSM states, RGB332 colours and the cell address helper.
package snake_pkg;

   localparam int unsigned DEF_GRID_COLS  = 40;
   localparam int unsigned DEF_GRID_ROWS  = 30;
   localparam int unsigned DEF_CELL_SHIFT = 4;

   typedef enum logic [1:0] {
      CellEmpty = 2'd0,
      CellBody  = 2'd1,
      CellHead  = 2'd2,
      CellFood  = 2'd3
   } cell_e;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StClear = 1'b1
   } state_e;

   // RGB332 packed as {red[2:0], green[2:0], blue[1:0]}
   localparam logic [7:0] RGB_BLACK  = 8'b000_000_00;
   localparam logic [7:0] RGB_WHITE  = 8'b111_111_11;
   localparam logic [7:0] RGB_GREEN  = 8'b000_111_00;
   localparam logic [7:0] RGB_YELLOW = 8'b111_111_00;
   localparam logic [7:0] RGB_RED    = 8'b111_000_00;

   // row * 40 + col, with the multiply done as two shifts
   function automatic logic [10:0] cell_addr(input logic [10:0] row, input logic [10:0] col);
      return (row << 5) + (row << 3) + col;
   endfunction

endpackage

// File: rtl/snake_render_if.sv
// Game-logic side of the renderer: cell update handshake and grid clear control.
interface snake_render_if;

   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_row;
   logic [5:0] wr_col;
   logic [1:0] wr_type;
   logic       clear_req;
   logic       clear_busy;

   modport master (
      output wr_valid, wr_row, wr_col, wr_type, clear_req,
      input  wr_ready, clear_busy
   );

   modport slave (
      input  wr_valid, wr_row, wr_col, wr_type, clear_req,
      output wr_ready, clear_busy
   );

endinterface

// File: rtl/snake_grid_ram.sv
// Cell grid storage: one synchronous read port and one write port that is shared between
// the clear sweep (writing empty) and game updates.
module snake_grid_ram #(
   parameter int unsigned DEPTH = 1200
) (
   input  logic        clk,
   input  logic        sweep_en,
   input  logic [10:0] sweep_addr,
   input  logic        game_we,
   input  logic [10:0] game_addr,
   input  logic [1:0]  game_data,
   input  logic [10:0] rd_addr,
   output logic [1:0]  rd_data
);

   logic [1:0]  mem [DEPTH];
   logic        we;
   logic [10:0] waddr;
   logic [1:0]  wdata;

   // The sweep owns the port; game writes are only offered while it is idle
   always_comb begin
      we    = sweep_en | game_we;
      waddr = sweep_en ? sweep_addr : game_addr;
      wdata = sweep_en ? 2'b00 : game_data;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rd_data <= (rd_addr < 11'(DEPTH)) ? mem[rd_addr] : 2'b00;
   end

endmodule

// File: rtl/snake_render.sv
// Snake game renderer: 3-stage pixel pipeline over a cell grid, vblank-gated cell
// updates and a clear sweep that runs after every reset or clear request.
module snake_render
   import snake_pkg::*;
#(
   parameter int unsigned GRID_COLS  = DEF_GRID_COLS,
   parameter int unsigned GRID_ROWS  = DEF_GRID_ROWS,
   parameter int unsigned CELL_SHIFT = DEF_CELL_SHIFT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   input  logic [9:0] r_pixel,
   input  logic [9:0] c_pixel,
   input  logic       video_on,
   snake_render_if.slave wr,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [1:0] blue,
   output logic       h_sync,
   output logic       v_sync
);

   localparam logic [10:0] LAST_ADDR  = 11'(GRID_ROWS * GRID_COLS - 1);
   localparam logic [9:0]  VIS_HEIGHT = 10'(GRID_ROWS << CELL_SHIFT);

   state_e      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic        sweep_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (wr.clear_req) state_d = StClear;
         end
         StClear: begin
            if (cnt_q == LAST_ADDR) state_d = StIdle;
            else                    cnt_d   = cnt_q + 11'd1;
         end
         default: state_d = StClear;
      endcase
   end

   always_comb begin
      sweep_en      = (state_q == StClear);
      wr.clear_busy = sweep_en;
      wr.wr_ready   = (state_q == StIdle) & ~rst & (r_pixel >= VIS_HEIGHT);
   end

   // Out-of-range updates complete the handshake but never reach memory
   logic        game_we;
   logic [10:0] game_addr;
   assign game_we   = wr.wr_valid & wr.wr_ready & (32'(wr.wr_row) < GRID_ROWS)
                      & (32'(wr.wr_col) < GRID_COLS);
   assign game_addr = cell_addr(11'(wr.wr_row), 11'(wr.wr_col));

   // Stage 1: cell address, border flag and delayed timing
   logic [9:0]  row_cell, col_cell;
   logic        border;
   logic [10:0] addr_q;
   logic        vid1_q, border1_q, hs1_q, vs1_q;

   assign row_cell = r_pixel >> CELL_SHIFT;
   assign col_cell = c_pixel >> CELL_SHIFT;
   assign border   = (row_cell == '0) || (row_cell == 10'(GRID_ROWS - 1)) ||
                     (col_cell == '0) || (col_cell == 10'(GRID_COLS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         vid1_q    <= 1'b0;
         border1_q <= 1'b0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
      end else begin
         addr_q    <= cell_addr(11'(row_cell), 11'(col_cell));
         vid1_q    <= video_on;
         border1_q <= border;
         hs1_q     <= h_sync_in;
         vs1_q     <= v_sync_in;
      end
   end

   // Stage 2: grid read, timing follows alongside
   logic [1:0] cell_rd;
   logic       vid2_q, border2_q, hs2_q, vs2_q;

   snake_grid_ram #(
      .DEPTH(GRID_ROWS * GRID_COLS)
   ) u_grid_ram (
      .clk       (clk),
      .sweep_en  (sweep_en),
      .sweep_addr(cnt_q),
      .game_we   (game_we),
      .game_addr (game_addr),
      .game_data (wr.wr_type),
      .rd_addr   (addr_q),
      .rd_data   (cell_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vid2_q    <= 1'b0;
         border2_q <= 1'b0;
         hs2_q     <= 1'b1;
         vs2_q     <= 1'b1;
      end else begin
         vid2_q    <= vid1_q;
         border2_q <= border1_q;
         hs2_q     <= hs1_q;
         vs2_q     <= vs1_q;
      end
   end

   // Stage 3: colour map
   logic [7:0] rgb_d, rgb_q;
   logic       hs3_q, vs3_q;

   always_comb begin
      rgb_d = RGB_BLACK;
      if (!vid2_q)        rgb_d = RGB_BLACK;
      else if (border2_q) rgb_d = RGB_WHITE;
      else if (sweep_en)  rgb_d = RGB_BLACK;
      else begin
         unique case (cell_e'(cell_rd))
            CellEmpty: rgb_d = RGB_BLACK;
            CellBody:  rgb_d = RGB_GREEN;
            CellHead:  rgb_d = RGB_YELLOW;
            CellFood:  rgb_d = RGB_RED;
            default:   rgb_d = RGB_BLACK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q <= RGB_BLACK;
         hs3_q <= 1'b1;
         vs3_q <= 1'b1;
      end else begin
         rgb_q <= rgb_d;
         hs3_q <= hs2_q;
         vs3_q <= vs2_q;
      end
   end

   assign red    = rgb_q[7:5];
   assign green  = rgb_q[4:2];
   assign blue   = rgb_q[1:0];
   assign h_sync = hs3_q;
   assign v_sync = vs3_q;

endmodule

// File: tb/tb_snake_render.sv
// Directed bench for snake_render: reset sweep, pipeline latency, colour priority,
// vblank-gated writes, out-of-range writes and clear/reset interaction.
module tb_snake_render;

   logic       clk = 1'b0;
   logic       rst;
   logic       h_sync_in, v_sync_in;
   logic [9:0] r_pixel, c_pixel;
   logic       video_on;
   logic [2:0] red, green;
   logic [1:0] blue;
   logic       h_sync, v_sync;
   logic [7:0] rgb;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   snake_render_if wr_bus ();

   snake_render dut (
      .clk      (clk),
      .rst      (rst),
      .h_sync_in(h_sync_in),
      .v_sync_in(v_sync_in),
      .r_pixel  (r_pixel),
      .c_pixel  (c_pixel),
      .video_on (video_on),
      .wr       (wr_bus),
      .red      (red),
      .green    (green),
      .blue     (blue),
      .h_sync   (h_sync),
      .v_sync   (v_sync)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic render(input logic [9:0] r, input logic [9:0] c, input logic vid,
                         output logic [7:0] pix);
      r_pixel  = r;
      c_pixel  = c;
      video_on = vid;
      step(3);
      pix = {red, green, blue};
   endtask

   task automatic write_cell(input logic [4:0] row, input logic [5:0] col,
                             input logic [1:0] typ, input string tag);
      r_pixel         = 10'd490;
      video_on        = 1'b0;
      wr_bus.wr_valid = 1'b1;
      wr_bus.wr_row   = row;
      wr_bus.wr_col   = col;
      wr_bus.wr_type  = typ;
      #1;
      check_eq({tag, "_ready"}, 32'(wr_bus.wr_ready), 32'd1);
      step(1);
      wr_bus.wr_valid = 1'b0;
   endtask

   task automatic wait_sweep(input string tag, input int exp);
      int n = 0;
      while (wr_bus.clear_busy === 1'b1 && n < 2000) begin
         step(1);
         n++;
      end
      check_eq(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst              = 1'b1;
      h_sync_in        = 1'b0;
      v_sync_in        = 1'b0;
      r_pixel          = '0;
      c_pixel          = '0;
      video_on         = 1'b1;
      wr_bus.wr_valid  = 1'b0;
      wr_bus.wr_row    = '0;
      wr_bus.wr_col    = '0;
      wr_bus.wr_type   = '0;
      wr_bus.clear_req = 1'b0;
      step(2);
      check_eq("rst_rgb", 32'({red, green, blue}), 32'h00);
      check_eq("rst_hsync", 32'(h_sync), 32'd1);
      check_eq("rst_vsync", 32'(v_sync), 32'd1);
      check_eq("rst_busy", 32'(wr_bus.clear_busy), 32'd1);
      check_eq("rst_ready", 32'(wr_bus.wr_ready), 32'd0);

      rst       = 1'b0;
      h_sync_in = 1'b1;
      v_sync_in = 1'b1;
      video_on  = 1'b0;
      wait_sweep("sweep_after_rst", 1200);

      // Sync and colour latency: 3 cycles
      r_pixel   = 10'd200;
      c_pixel   = 10'd300;
      video_on  = 1'b1;
      h_sync_in = 1'b0;
      v_sync_in = 1'b0;
      step(2);
      check_eq("hsync_lat2", 32'(h_sync), 32'd1);
      step(1);
      check_eq("hsync_lat3", 32'(h_sync), 32'd0);
      check_eq("vsync_lat3", 32'(v_sync), 32'd0);
      check_eq("interior_empty", 32'({red, green, blue}), 32'h00);
      h_sync_in = 1'b1;
      v_sync_in = 1'b1;

      render(10'd0, 10'd100, 1'b1, rgb);
      check_eq("border_top", 32'(rgb), 32'hFF);
      render(10'd0, 10'd100, 1'b0, rgb);
      check_eq("border_video_off", 32'(rgb), 32'h00);
      render(10'd200, 10'd639, 1'b1, rgb);
      check_eq("border_right", 32'(rgb), 32'hFF);
      render(10'd479, 10'd300, 1'b1, rgb);
      check_eq("border_bottom", 32'(rgb), 32'hFF);

      // Update held during active video waits for vblank
      r_pixel         = 10'd100;
      video_on        = 1'b1;
      wr_bus.wr_valid = 1'b1;
      wr_bus.wr_row   = 5'd5;
      wr_bus.wr_col   = 6'd10;
      wr_bus.wr_type  = 2'd1;
      #1;
      check_eq("ready_active", 32'(wr_bus.wr_ready), 32'd0);
      step(1);
      check_eq("ready_active_hold", 32'(wr_bus.wr_ready), 32'd0);
      r_pixel = 10'd480;
      #1;
      check_eq("ready_vblank", 32'(wr_bus.wr_ready), 32'd1);
      step(1);
      wr_bus.wr_valid = 1'b0;

      render(10'd88, 10'd168, 1'b1, rgb);
      check_eq("body", 32'(rgb), 32'h1C);
      write_cell(5'd7, 6'd12, 2'd2, "wr_head");
      render(10'd115, 10'd197, 1'b1, rgb);
      check_eq("head", 32'(rgb), 32'hFC);
      write_cell(5'd8, 6'd20, 2'd3, "wr_food");
      render(10'd130, 10'd325, 1'b1, rgb);
      check_eq("food", 32'(rgb), 32'hE0);

      // Out-of-range updates; col 50 on row 5 would alias to row 6 col 10
      write_cell(5'd31, 6'd10, 2'd3, "oob_row");
      write_cell(5'd5, 6'd50, 2'd3, "oob_col");
      render(10'd88, 10'd168, 1'b1, rgb);
      check_eq("oob_keep_body", 32'(rgb), 32'h1C);
      render(10'd98, 10'd162, 1'b1, rgb);
      check_eq("oob_no_alias", 32'(rgb), 32'h00);

      write_cell(5'd9, 6'd9, 2'd3, "wr_food2");
      render(10'd145, 10'd145, 1'b1, rgb);
      check_eq("food2", 32'(rgb), 32'hE0);

      // Clear request coinciding with an accepted write
      r_pixel          = 10'd490;
      wr_bus.wr_valid  = 1'b1;
      wr_bus.wr_row    = 5'd10;
      wr_bus.wr_col    = 6'd10;
      wr_bus.wr_type   = 2'd2;
      wr_bus.clear_req = 1'b1;
      #1;
      check_eq("ready_with_clear", 32'(wr_bus.wr_ready), 32'd1);
      step(1);
      wr_bus.wr_valid  = 1'b0;
      wr_bus.clear_req = 1'b0;
      check_eq("clear_started", 32'(wr_bus.clear_busy), 32'd1);
      check_eq("ready_busy", 32'(wr_bus.wr_ready), 32'd0);

      // Reset 500 cycles into the sweep restarts it
      step(499);
      check_eq("busy_mid_sweep", 32'(wr_bus.clear_busy), 32'd1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      wait_sweep("sweep_restart", 1200);
      render(10'd145, 10'd145, 1'b1, rgb);
      check_eq("food_cleared", 32'(rgb), 32'h00);
      render(10'd88, 10'd168, 1'b1, rgb);
      check_eq("body_cleared", 32'(rgb), 32'h00);

      // A second clear_req mid-sweep must not restart it
      wr_bus.clear_req = 1'b1;
      step(1);
      wr_bus.clear_req = 1'b0;
      check_eq("clear2_started", 32'(wr_bus.clear_busy), 32'd1);
      step(596);
      render(10'd0, 10'd100, 1'b1, rgb);
      check_eq("border_during_clear", 32'(rgb), 32'hFF);
      wr_bus.clear_req = 1'b1;
      step(1);
      wr_bus.clear_req = 1'b0;
      wait_sweep("no_restart", 600);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
